// File: rtl/ni_inject_queue.sv
// ni_inject_queue: NI injection FIFO with paced valid/ready output register.
// Define NI_SELF_DROP_EN to filter flits addressed to LOCAL_ID.
module ni_inject_queue #(
    parameter int         DEPTH    = 8,
    parameter int         INJ_GAP  = 0,
    parameter logic [3:0] LOCAL_ID = 4'd0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [19:0]            in_data,
    input  logic                   in_valid,
    output logic [19:0]            flit_out,
    output logic                   flit_valid,
    input  logic                   flit_ready,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overflow,
    output logic [15:0]            inj_count,
    output logic [15:0]            drop_count,
    output logic                   idle
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t        state, state_nx;
    logic [19:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;
    logic [7:0]    gap_cnt, gap_nx;
    logic          full, pop, push, drop, accept;
    logic          rem_nz, avail, load, valid_nx;
    logic [19:0]   load_data;

`ifdef NI_SELF_DROP_EN
    logic [15:0] self_count;
    logic        self_hit;

    assign self_hit = in_valid && (in_data[3:0] == LOCAL_ID);
    assign accept   = in_valid && !self_hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            self_count <= '0;
        else if (self_hit && self_count != 16'hFFFF)
            self_count <= self_count + 16'd1;
    end
`else
    logic unused_local_id;

    assign unused_local_id = ^LOCAL_ID;
    assign accept          = in_valid;
`endif

    assign full   = (fifo_count == FULL_CNT);
    assign pop    = flit_valid && flit_ready;
    assign push   = accept && (!full || pop);
    assign drop   = accept && full && !pop;
    assign rd_nxt = rd_ptr + 1'b1;
    assign idle   = (fifo_count == '0) && (state == IDLE);

    // Head candidate once the current head (if popped) has left the queue.
    always_comb begin
        rem_nz    = pop ? (fifo_count > 1) : (fifo_count != '0);
        avail     = rem_nz || push;
        load_data = in_data;
        if (rem_nz)
            load_data = pop ? mem[rd_nxt] : mem[rd_ptr];
    end

    always_comb begin
        state_nx = state;
        gap_nx   = gap_cnt;
        valid_nx = flit_valid;
        load     = 1'b0;
        unique case (state)
            IDLE: begin
                if (avail) begin
                    state_nx = SEND;
                    valid_nx = 1'b1;
                    load     = 1'b1;
                end
            end
            SEND: begin
                if (pop) begin
                    if (INJ_GAP == 0) begin
                        if (avail) begin
                            load = 1'b1;
                        end else begin
                            state_nx = IDLE;
                            valid_nx = 1'b0;
                        end
                    end else begin
                        state_nx = GAP;
                        valid_nx = 1'b0;
                        gap_nx   = 8'(INJ_GAP);
                    end
                end
            end
            GAP: begin
                gap_nx = gap_cnt - 8'd1;
                if (gap_cnt <= 8'd1) begin
                    gap_nx = '0;
                    if (avail) begin
                        state_nx = SEND;
                        valid_nx = 1'b1;
                        load     = 1'b1;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                valid_nx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            gap_cnt    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            flit_out   <= '0;
            flit_valid <= 1'b0;
            overflow   <= 1'b0;
            inj_count  <= '0;
            drop_count <= '0;
        end else begin
            state      <= state_nx;
            gap_cnt    <= gap_nx;
            flit_valid <= valid_nx;
            if (load)
                flit_out <= load_data;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_nxt;
            if (push && !pop)
                fifo_count <= fifo_count + 1'b1;
            else if (pop && !push)
                fifo_count <= fifo_count - 1'b1;
            if (drop)
                overflow <= 1'b1;
            if (pop && inj_count != 16'hFFFF)
                inj_count <= inj_count + 16'd1;
            if (drop && drop_count != 16'hFFFF)
                drop_count <= drop_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_ni_inject_queue.sv
// tb_ni_inject_queue: random and directed checks of two NI queues
// (INJ_GAP 0 and 3) against a queue-level reference model.
module tb_ni_inject_queue;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [19:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        flit_ready = 1'b0;

    logic [19:0] fo  [2];
    logic        fv  [2];
    logic [3:0]  fc  [2];
    logic        ov  [2];
    logic [15:0] ic  [2];
    logic [15:0] dc  [2];
    logic        idl [2];

    int n_tests = 0;
    int n_fail  = 0;
    int t = 0;

    always #5 clk = ~clk;

    ni_inject_queue #(.DEPTH(DEPTH), .INJ_GAP(0), .LOCAL_ID(4'd0)) u_g0 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .flit_out(fo[0]), .flit_valid(fv[0]), .flit_ready(flit_ready),
        .fifo_count(fc[0]), .overflow(ov[0]), .inj_count(ic[0]),
        .drop_count(dc[0]), .idle(idl[0])
    );

    ni_inject_queue #(.DEPTH(DEPTH), .INJ_GAP(3), .LOCAL_ID(4'd0)) u_g3 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .flit_out(fo[1]), .flit_valid(fv[1]), .flit_ready(flit_ready),
        .fifo_count(fc[1]), .overflow(ov[1]), .inj_count(ic[1]),
        .drop_count(dc[1]), .idle(idl[1])
    );

    // Reference: a flit queue plus the earliest cycle an injection may occur.
    logic [19:0] mbuf [2][DEPTH];
    int          mhd   [2];
    int          msz   [2];
    int          mnext [2];
    int          minj  [2];
    int          mdrop [2];
    bit          movf  [2];

    function automatic int gap_of(int k);
        return (k == 0) ? 0 : 3;
    endfunction

    function automatic bit exp_valid(int k);
        return (msz[k] != 0) && (t >= mnext[k]);
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0d)",
                     tag, got, exp, t);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mhd[k] = 0; msz[k] = 0; mnext[k] = 0;
            minj[k] = 0; mdrop[k] = 0; movf[k] = 0;
        end
    endtask

    task automatic model_step(int k, bit v, logic [19:0] d, bit r);
        bit pop, push, drop, self_f;
        pop = exp_valid(k) && r;
        self_f = 1'b0;
`ifdef NI_SELF_DROP_EN
        self_f = (d[3:0] == 4'd0);
`endif
        push = v && !self_f && (msz[k] < DEPTH || pop);
        drop = v && !self_f && (msz[k] == DEPTH) && !pop;
        if (pop) begin
            mhd[k] = (mhd[k] + 1) % DEPTH;
            msz[k]--;
            if (minj[k] < 65535) minj[k]++;
            mnext[k] = t + 1 + gap_of(k);
        end
        if (push) begin
            mbuf[k][(mhd[k] + msz[k]) % DEPTH] = d;
            msz[k]++;
        end
        if (drop) begin
            movf[k] = 1'b1;
            if (mdrop[k] < 65535) mdrop[k]++;
        end
    endtask

    task automatic check_all();
        bit ev;
        for (int k = 0; k < 2; k++) begin
            ev = exp_valid(k);
            chk($sformatf("u%0d valid", k), 32'(fv[k]), 32'(ev));
            if (ev)
                chk($sformatf("u%0d flit", k), 32'(fo[k]),
                    32'(mbuf[k][mhd[k]]));
            chk($sformatf("u%0d count", k), 32'(fc[k]), msz[k]);
            chk($sformatf("u%0d ovf", k), 32'(ov[k]), 32'(movf[k]));
            chk($sformatf("u%0d inj", k), 32'(ic[k]), minj[k]);
            chk($sformatf("u%0d drop", k), 32'(dc[k]), mdrop[k]);
            chk($sformatf("u%0d idle", k), 32'(idl[k]),
                32'(msz[k] == 0 && !ev && t >= mnext[k]));
        end
    endtask

    task automatic cycle(bit v, logic [19:0] d, bit r);
        in_valid   = v;
        in_data    = d;
        flit_ready = r;
        for (int k = 0; k < 2; k++) model_step(k, v, d, r);
        @(posedge clk);
        #1;
        t++;
        check_all();
    endtask

    task automatic check_reset_vals(string tag);
        for (int k = 0; k < 2; k++) begin
            chk({tag, " valid"}, 32'(fv[k]), 0);
            chk({tag, " flit"}, 32'(fo[k]), 0);
            chk({tag, " count"}, 32'(fc[k]), 0);
            chk({tag, " ovf"}, 32'(ov[k]), 0);
            chk({tag, " inj"}, 32'(ic[k]), 0);
            chk({tag, " drop"}, 32'(dc[k]), 0);
            chk({tag, " idle"}, 32'(idl[k]), 1);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        in_valid   = 1'b0;
        flit_ready = 1'b0;
        rst        = 1'b0;
        model_reset();
        #1;
        check_reset_vals("rst");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        t++;
        check_all();
    endtask

    function automatic logic [19:0] seq_flit(int i);
        return {16'h0301 + 16'(i), 4'(i % 8)};
    endfunction

    initial begin
        model_reset();
        #3;
        check_reset_vals("por");
        apply_reset();

        // Back-to-back stream with the router always ready.
        for (int i = 0; i < 30; i++) cycle(1'b1, seq_flit(i), 1'b1);
        for (int i = 0; i < 40; i++) cycle(1'b0, '0, 1'b1);
        chk("s1 inj30", 32'(ic[0]), 30);
        chk("s1 drop0", 32'(dc[0]), 0);
        chk("s1 ovf0", 32'(ov[0]), 0);
        chk("s1 idle", 32'(idl[0]), 1);

        // Stalled router: overfill by two, head must hold.
        apply_reset();
        for (int i = 0; i < 10; i++) cycle(1'b1, seq_flit(i), 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0);
        chk("s2 full", 32'(fc[0]), 8);
        chk("s2 drop2", 32'(dc[0]), 2);
        chk("s2 ovf", 32'(ov[0]), 1);
        chk("s2 head", 32'(fo[0]), 32'h03010);

        // Push and pop together while full.
        cycle(1'b1, 20'hABCD5, 1'b1);
        chk("s3 full", 32'(fc[0]), 8);
        chk("s3 drop", 32'(dc[0]), 2);
        chk("s3 next", 32'(fo[0]), 32'(seq_flit(1)));
        for (int i = 0; i < 40; i++) cycle(1'b0, '0, 1'b1);

        // Gap pacing on the INJ_GAP=3 instance.
        apply_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, seq_flit(i), 1'b0);
        for (int j = 0; j < 13; j++) begin
            chk("s4 pattern", 32'(fv[1]), 32'(j % 4 == 0));
            cycle(1'b0, '0, 1'b1);
        end
        chk("s4 inj4", 32'(ic[1]), 4);

        // Asynchronous reset in the middle of a burst.
        apply_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, seq_flit(i), 1'b0);
        rst = 1'b0;
        model_reset();
        #2;
        check_reset_vals("s5 mid");
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b1);

`ifdef NI_SELF_DROP_EN
        apply_reset();
        cycle(1'b1, 20'h03010, 1'b1);
        cycle(1'b1, 20'h03101, 1'b1);
        for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1);
        chk("s6 inj1", 32'(ic[0]), 1);
        chk("s6 drop0", 32'(dc[0]), 0);
`endif

        // Randomized traffic.
        apply_reset();
        for (int i = 0; i < 1500; i++)
            cycle($urandom_range(99) < 60, 20'($urandom),
                  $urandom_range(99) < 55);
        for (int i = 0; i < 40; i++) cycle(1'b0, '0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
